// File: rtl/pentarv_pkg.sv
// Shared definitions for the pentarv pipeline: ALU op codes, forwarding
// selects and the multiplier state encoding.
package pentarv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: latches operands on start, runs one step per
// cycle for MUL_CYCLES cycles, then holds done for one cycle.
module mul_seq
  import pentarv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  mul_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      case (state_q)
        MUL_IDLE: if (start) begin
          mcand_q  <= a;
          mplier_q <= b;
          acc_q    <= '0;
          cnt_q    <= '0;
          state_q  <= MUL_BUSY;
        end
        MUL_BUSY: begin
          // only the low XLEN bits survive, so the multiplicand just shifts out
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_CYCLES - 1)) state_q <= MUL_DONE;
        end
        MUL_DONE: state_q <= MUL_IDLE;
        default:  state_q <= MUL_IDLE;
      endcase
    end
  end

  assign busy    = (state_q == MUL_BUSY);
  assign done    = (state_q == MUL_DONE);
  assign product = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage plus EX/MEM register. Define EXEC_MUL_EN to build the
// iterative multiplier; otherwise MUL yields 0 and StallE is tied low.
module execute_stage
  import pentarv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] src_a, write_data, src_b, alu_out, alu_result;
  logic            zero;

  always_comb begin
    case (ForwardAE)
      FWD_M:   src_a = ALUResultM;
      FWD_W:   src_a = ResultW;
      default: src_a = RD1_E;
    endcase
    case (ForwardBE)
      FWD_M:   write_data = ALUResultM;
      FWD_W:   write_data = ResultW;
      default: write_data = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : write_data;
  end

  // MUL and unused codes fall through to 0; the multiplier result is muxed in later
  always_comb begin
    alu_out = '0;
    case (ALUControlE)
      ALU_ADD:  alu_out = src_a + src_b;
      ALU_SUB:  alu_out = src_a - src_b;
      ALU_AND:  alu_out = src_a & src_b;
      ALU_OR:   alu_out = src_a | src_b;
      ALU_XOR:  alu_out = src_a ^ src_b;
      ALU_SLT:  alu_out = XLEN'($signed(src_a) < $signed(src_b));
      ALU_SLTU: alu_out = XLEN'(src_a < src_b);
      ALU_SLL:  alu_out = src_a << src_b[4:0];
      ALU_SRL:  alu_out = src_a >> src_b[4:0];
      ALU_SRA:  alu_out = $signed(src_a) >>> src_b[4:0];
      default:  alu_out = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic            mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;

  // operands are sampled only in the start cycle; the forward sources move during the stall
  assign mul_start = rst & (ALUControlE == ALU_MUL) & ~mul_busy & ~mul_done;

  mul_seq #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst_n   (rst),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign StallE     = mul_start | mul_busy;
  assign alu_result = mul_done ? mul_product : alu_out;
`else
  logic unused_mul_cycles;
  assign unused_mul_cycles = ^32'(MUL_CYCLES);
  assign StallE     = 1'b0;
  assign alu_result = alu_out;
`endif

  assign zero      = (alu_result == '0);
  assign PCSrcE    = rst & ~StallE & ((BranchE & zero) | JumpE);
  assign PCTargetE = PCE + Imm_Ext_E;

  logic            reg_write_d, reg_write_q, mem_write_d, mem_write_q;
  logic [1:0]      result_src_d, result_src_q;
  logic [4:0]      rd_d, rd_q;
  logic [XLEN-1:0] alu_result_d, alu_result_q, write_data_d, write_data_q;
  logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;

  // a stalled cycle pushes a bubble into MEM
  always_comb begin
    reg_write_d  = RegWriteE;
    mem_write_d  = MemWriteE;
    result_src_d = ResultSrcE;
    rd_d         = RD_E;
    alu_result_d = alu_result;
    write_data_d = write_data;
    pc_plus4_d   = PCPlus4E;
    if (StallE) begin
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = '0;
      rd_d         = '0;
      alu_result_d = '0;
      write_data_d = '0;
      pc_plus4_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus a randomized run
// against an arithmetic reference model of the execute stage.
module tb_execute_stage;
  import pentarv_pkg::*;

  localparam int MUL_CYC = 32;

  logic        clk = 1'b0, rst = 1'b0;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic        PCSrcE, StallE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;

  int vectors = 0, miscompares = 0;
  logic [31:0] exp_alu_m = 32'd0;

  execute_stage #(.XLEN(32), .MUL_CYCLES(MUL_CYC)) dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallE(StallE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] rf);
    if (s == 2'b10) return exp_alu_m;
    if (s == 2'b01) return ResultW;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] ones;
    sh   = b % 32;
    ones = 32'hFFFF_FFFF;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return (a >> sh) | ((a[31] && sh != 0) ? ~(ones >> sh) : 32'd0);
`ifdef EXEC_MUL_EN
      ALU_MUL:  return a * b;
`else
      ALU_MUL:  return 32'd0;
`endif
      default:  return 32'd0;
    endcase
  endfunction

  // Called at a negedge with inputs set; checks one single-cycle op end to end.
  task automatic run_op(input string tag);
    logic [31:0] sa, wd, sb, res;
    sa  = fwd(ForwardAE, RD1_E);
    wd  = fwd(ForwardBE, RD2_E);
    sb  = ALUSrcE ? Imm_Ext_E : wd;
    res = ref_alu(ALUControlE, sa, sb);
    #1;
    chk({tag, "_stall"}, StallE, 0);
    chk({tag, "_pcsrc"}, PCSrcE, ((BranchE && res == 0) || JumpE) ? 1 : 0);
    chk({tag, "_pctgt"}, PCTargetE, PCE + Imm_Ext_E);
    @(posedge clk); #1;
    chk({tag, "_alu"}, ALUResultM, res);
    chk({tag, "_rd"}, RD_M, RD_E);
    chk({tag, "_rw"}, RegWriteM, RegWriteE);
    chk({tag, "_mw"}, MemWriteM, MemWriteE);
    chk({tag, "_wd"}, WriteDataM, wd);
    chk({tag, "_pc4"}, PCPlus4M, PCPlus4E);
    chk({tag, "_rsrc"}, ResultSrcM, ResultSrcE);
    exp_alu_m = res;
    @(negedge clk);
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic src);
    ALUControlE = op; RD1_E = a; RD2_E = b; Imm_Ext_E = imm; ALUSrcE = src;
    ForwardAE = FWD_REG; ForwardBE = FWD_REG; BranchE = 0; JumpE = 0;
    RegWriteE = 1; MemWriteE = 0; ResultSrcE = 2'b00; RD_E = 5'd3;
    PCE = 32'h40; PCPlus4E = 32'h44;
  endtask

  initial begin
    set_op(ALU_ADD, 0, 0, 0, 0);
    ResultW = 0; RegWriteE = 0; JumpE = 1;
    #2;
    chk("rst_alu", ALUResultM, 0);
    chk("rst_rd", RD_M, 0);
    chk("rst_rw", RegWriteM, 0);
    chk("rst_pc4", PCPlus4M, 0);
    chk("rst_stall", StallE, 0);
    chk("rst_pcsrc_jump", PCSrcE, 0);
    @(negedge clk); rst = 1;

    set_op(ALU_ADD, 5, 0, 7, 1);
    run_op("add");

    set_op(ALU_ADD, 32'h10, 0, 0, 1);
    run_op("mk10");
    set_op(ALU_SUB, 32'hDEAD, 32'hBEEF, 32'h20, 0);
    ForwardAE = FWD_M; ForwardBE = FWD_W; ResultW = 32'h10;
    BranchE = 1; PCE = 32'h100;
    run_op("sub_br");

    set_op(ALU_SRA, 32'h8000_0000, 0, 32'h24, 1);
    run_op("sra");
    set_op(4'd13, 32'h1234, 0, 32'h1, 1);
    BranchE = 1;
    run_op("unused_op");

`ifdef EXEC_MUL_EN
    begin
      int stalls;
      set_op(ALU_ADD, 32'hFFFF_FFFF, 0, 0, 1);
      run_op("mkff");
      set_op(ALU_MUL, 32'h0, 32'd3, 32'h0, 0);
      ForwardAE = FWD_M; RD_E = 5'd5; JumpE = 1;
      stalls = 0;
      for (int c = 0; c < 200; c++) begin
        #1;
        if (!StallE) break;
        stalls++;
        chk("mul_pcsrc_stall", PCSrcE, 0);
        ResultW = $urandom;
        @(posedge clk); #1;
        chk("mul_bubble_alu", ALUResultM, 0);
        chk("mul_bubble_rw", RegWriteM, 0);
        chk("mul_bubble_rd", RD_M, 0);
        @(negedge clk);
      end
      chk("mul_stall_cycles", stalls, MUL_CYC + 1);
      chk("mul_done_pcsrc", PCSrcE, 1);
      @(posedge clk); #1;
      chk("mul_result", ALUResultM, 32'hFFFF_FFFD);
      chk("mul_rd", RD_M, 5);
      chk("mul_rw", RegWriteM, 1);
      exp_alu_m = 32'hFFFF_FFFD;
      @(negedge clk);

      set_op(ALU_MUL, 32'd7, 32'd9, 0, 0);
      repeat (11) @(posedge clk);
      #2; rst = 0; #1;
      chk("rstmul_stall", StallE, 0);
      chk("rstmul_alu", ALUResultM, 0);
      chk("rstmul_rw", RegWriteM, 0);
      chk("rstmul_pcsrc", PCSrcE, 0);
      exp_alu_m = 0;
      @(negedge clk);
      set_op(ALU_ADD, 32'd100, 0, 32'd23, 1);
      rst = 1;
      run_op("add_after_rst");
    end
`else
    set_op(ALU_MUL, 32'hFFFF_FFFF, 32'd3, 0, 0);
    run_op("mul_off");
    set_op(ALU_ADD, 32'd9, 0, 32'd1, 1);
    #3; rst = 0; #1;
    chk("rstmid_alu", ALUResultM, 0);
    chk("rstmid_rw", RegWriteM, 0);
    chk("rstmid_stall", StallE, 0);
    exp_alu_m = 0;
    @(negedge clk);
    rst = 1;
    run_op("add_after_rst");
`endif

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
`ifdef EXEC_MUL_EN
      if (op == ALU_MUL) op = ALU_SUB;
`endif
      ALUControlE = op;
      RD1_E = $urandom; RD2_E = (i % 5 == 0) ? RD1_E : $urandom;
      Imm_Ext_E = (i % 3 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      ALUSrcE = 1'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      ResultW = $urandom; BranchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 2'($urandom);
      RD_E = 5'($urandom); PCE = $urandom; PCPlus4E = $urandom;
      run_op("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
